uart_prog_loader: RTL and testbench

Boot-load controller between uart_rx and the instruction/data RAM of the rv32i SoC. While program mode is requested (progEnB low), it holds the core in reset and packs received UART bytes into little-endian 32-bit words. It writes each word to RAM starting at BASE_ADDR. On leaving program mode it flushes any partial word, then releases the core after a fixed reset-hold interval.

---
 rtl/rv32i_soc_pkg.sv | 30 +++
 rtl/sync_2ff.sv | 29 ++
 rtl/uart_prog_loader.sv | 189 ++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_soc_pkg.sv
// Shared definitions for the rv32i SoC boot-load path: loader state
// encoding, the partial-word byte-enable helper and the default core
// reset-hold length.
package rv32i_soc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_LOAD    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_FLUSH   = 3'd4,
        ST_RELEASE = 3'd5
    } loader_state_e;

    localparam int unsigned RST_HOLD_DEFAULT = 32'd4;

    // Byte enables for a word whose low lanes are filled; a lane count of
    // zero means the word is complete (all four lanes).
    function automatic logic [3:0] lane_mask(input logic [1:0] lanes_filled);
        logic [3:0] mask;
        case (lanes_filled)
            2'd1:    mask = 4'b0001;
            2'd2:    mask = 4'b0011;
            2'd3:    mask = 4'b0111;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
// The reset value is a parameter so an inactive level can be held
// while the block is in reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_prog_loader.sv
// Boot-load controller: while the program pin is held low the rv32i core
// stays in reset and received UART bytes are packed little-endian into
// 32-bit words written to RAM from BASE_ADDR upward. Leaving program mode
// flushes any partial word and releases the core after a reset-hold delay.
module uart_prog_loader
    import rv32i_soc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_BYTES = 32768,
    parameter int unsigned RST_HOLD  = RST_HOLD_DEFAULT
) (
    input  logic              clk,
    input  logic              rstB,
    input  logic              progEnB,
    input  logic              rxDataEn,
    input  logic [7:0]        rxData,
    output logic              rxFfFull,
    output logic              memWrEn,
    input  logic              memWrReady,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWrData,
    output logic [3:0]        memByteEn,
    output logic              coreRstB,
    output logic              busy,
    output logic [15:0]       byteCount,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BASE_WORD = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1);
    localparam logic [15:0]       MAX_COUNT = 16'(MAX_BYTES);
    // RST_HOLD must be at least 1.
    localparam logic [15:0]       HOLD_LAST = 16'(RST_HOLD - 1);

    loader_state_e      state_r;
    logic [15:0]        hold_cnt_r;
    logic [15:0]        byte_cnt_r;
    logic               core_rst_b_r;
    logic               busy_r;
    logic               err_r;
    logic               mem_wr_en_r;
    logic               rx_ff_full_r;
    logic [ADDR_W-1:0]  mem_addr_r;
    logic [31:0]        mem_wr_data_r;
    logic [3:0]         mem_byte_en_r;
    logic               prog_en_sync_s;
    logic               prog_req_s;
    logic [1:0]         lane_s;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_prog_sync (
        .clk   (clk),
        .rst_n (rstB),
        .d     (progEnB),
        .q     (prog_en_sync_s)
    );

    assign prog_req_s = ~prog_en_sync_s;
    // The word register doubles as the write-data output; the lane is the
    // low two bits of the session byte count.
    assign lane_s     = byte_cnt_r[1:0];

    // Loader sequencing with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            state_r       <= ST_RELEASE;
            hold_cnt_r    <= 16'd0;
            byte_cnt_r    <= 16'd0;
            core_rst_b_r  <= 1'b0;
            busy_r        <= 1'b1;
            err_r         <= 1'b0;
            mem_wr_en_r   <= 1'b0;
            rx_ff_full_r  <= 1'b0;
            mem_addr_r    <= BASE_WORD;
            mem_wr_data_r <= 32'd0;
            mem_byte_en_r <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (prog_req_s) begin
                        state_r      <= ST_ARM;
                        core_rst_b_r <= 1'b0;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_ARM: begin
                    byte_cnt_r    <= 16'd0;
                    err_r         <= 1'b0;
                    mem_wr_data_r <= 32'd0;
                    mem_byte_en_r <= 4'd0;
                    mem_addr_r    <= BASE_WORD;
                    state_r       <= ST_LOAD;
                end
                ST_LOAD: begin
                    // A byte strobe wins over an exit request; exit is
                    // re-evaluated on the following cycle.
                    if (rxDataEn) begin
                        if (byte_cnt_r < MAX_COUNT) begin
                            mem_wr_data_r[{lane_s, 3'b000} +: 8] <= rxData;
                            byte_cnt_r <= byte_cnt_r + 16'd1;
                            if (lane_s == 2'd3) begin
                                state_r       <= ST_WRITE;
                                mem_wr_en_r   <= 1'b1;
                                rx_ff_full_r  <= 1'b1;
                                mem_byte_en_r <= 4'hF;
                            end else begin
                                state_r       <= ST_LOAD;
                            end
                        end else begin
                            err_r   <= 1'b1;
                            state_r <= ST_LOAD;
                        end
                    end else if (!prog_req_s) begin
                        if (lane_s != 2'd0) begin
                            state_r       <= ST_FLUSH;
                            mem_wr_en_r   <= 1'b1;
                            rx_ff_full_r  <= 1'b1;
                            mem_byte_en_r <= lane_mask(lane_s);
                        end else begin
                            state_r    <= ST_RELEASE;
                            hold_cnt_r <= 16'd0;
                        end
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_WRITE, ST_FLUSH: begin
                    // Bytes cannot be buffered while a write is outstanding.
                    if (rxDataEn) begin
                        err_r <= 1'b1;
                    end else begin
                        err_r <= err_r;
                    end
                    if (memWrReady) begin
                        mem_wr_en_r   <= 1'b0;
                        rx_ff_full_r  <= 1'b0;
                        mem_addr_r    <= mem_addr_r + ADDR_STEP;
                        mem_wr_data_r <= 32'd0;
                        mem_byte_en_r <= 4'd0;
                        if (state_r == ST_WRITE) begin
                            state_r <= ST_LOAD;
                        end else begin
                            state_r    <= ST_RELEASE;
                            hold_cnt_r <= 16'd0;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RELEASE: begin
                    if (prog_req_s) begin
                        state_r <= ST_ARM;
                    end else if (hold_cnt_r == HOLD_LAST) begin
                        state_r      <= ST_IDLE;
                        hold_cnt_r   <= 16'd0;
                        core_rst_b_r <= 1'b1;
                        busy_r       <= 1'b0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + 16'd1;
                    end
                end
                default: begin
                    // Unreachable encodings fall back to holding the core.
                    state_r      <= ST_RELEASE;
                    hold_cnt_r   <= 16'd0;
                    core_rst_b_r <= 1'b0;
                    busy_r       <= 1'b1;
                    mem_wr_en_r  <= 1'b0;
                    rx_ff_full_r <= 1'b0;
                end
            endcase
        end
    end

    assign rxFfFull  = rx_ff_full_r;
    assign memWrEn   = mem_wr_en_r;
    assign memAddr   = mem_addr_r;
    assign memWrData = mem_wr_data_r;
    assign memByteEn = mem_byte_en_r;
    assign coreRstB  = core_rst_b_r;
    assign busy      = busy_r;
    assign byteCount = byte_cnt_r;
    assign err       = err_r;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: two instances (default MAX_BYTES and
// MAX_BYTES=8) share stimulus; a session-level model predicts the outputs
// of each every cycle, and directed sequences pin literal results.
module tb_uart_prog_loader;

    localparam int HOLD = 4;
    localparam int MODE_RUN  = 0;
    localparam int MODE_ARM  = 1;
    localparam int MODE_LOAD = 2;
    localparam int MODE_HOLD = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstB = 1'b0;
    logic        progEnB = 1'b1;
    logic        rxDataEn = 1'b0;
    logic [7:0]  rxData = 8'd0;
    logic        memWrReady = 1'b1;

    logic        rxFfFull_a, memWrEn_a, coreRstB_a, busy_a, err_a;
    logic [12:0] memAddr_a;
    logic [31:0] memWrData_a;
    logic [3:0]  memByteEn_a;
    logic [15:0] byteCount_a;
    logic        rxFfFull_b, memWrEn_b, coreRstB_b, busy_b, err_b;
    logic [12:0] memAddr_b;
    logic [31:0] memWrData_b;
    logic [3:0]  memByteEn_b;
    logic [15:0] byteCount_b;

    uart_prog_loader u_dut_a (
        .clk(clk), .rstB(rstB), .progEnB(progEnB), .rxDataEn(rxDataEn),
        .rxData(rxData), .rxFfFull(rxFfFull_a), .memWrEn(memWrEn_a),
        .memWrReady(memWrReady), .memAddr(memAddr_a), .memWrData(memWrData_a),
        .memByteEn(memByteEn_a), .coreRstB(coreRstB_a), .busy(busy_a),
        .byteCount(byteCount_a), .err(err_a)
    );

    uart_prog_loader #(.MAX_BYTES(8)) u_dut_b (
        .clk(clk), .rstB(rstB), .progEnB(progEnB), .rxDataEn(rxDataEn),
        .rxData(rxData), .rxFfFull(rxFfFull_b), .memWrEn(memWrEn_b),
        .memWrReady(memWrReady), .memAddr(memAddr_b), .memWrData(memWrData_b),
        .memByteEn(memByteEn_b), .coreRstB(coreRstB_b), .busy(busy_b),
        .byteCount(byteCount_b), .err(err_b)
    );

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    bit  chk_en = 1'b0;
    bit  rnd_ready = 1'b0;
    int  hs_cyc_a = 0;
    logic [48:0] log_a[$];
    logic [48:0] log_b[$];

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, inst, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Record every completed write handshake per instance.
    always @(posedge clk) begin
        if (rstB === 1'b1) begin
            if (memWrEn_a === 1'b1 && memWrReady === 1'b1) begin
                log_a.push_back({memAddr_a, memWrData_a, memByteEn_a});
                hs_cyc_a = cyc + 1;
            end
            if (memWrEn_b === 1'b1 && memWrReady === 1'b1)
                log_b.push_back({memAddr_b, memWrData_b, memByteEn_b});
        end
    end

    function automatic logic [48:0] entry_a(input int idx);
        if (idx < log_a.size()) return log_a[idx];
        return '1;
    endfunction

    function automatic logic [48:0] entry_b(input int idx);
        if (idx < log_b.size()) return log_b[idx];
        return '1;
    endfunction

    // ---------------- session-level reference model ----------------
    bit          s1 = 1'b1, s2 = 1'b1, m_req;
    int          m_mode[2], m_hold[2], m_count[2], m_nb[2], m_next[2];
    bit          m_pend[2], m_flush[2], m_err[2], e_core[2], e_busy[2];
    logic [31:0] m_word[2], e_data[2];
    int          e_addr[2], e_be[2];

    function automatic int max_of(input int i);
        return (i == 0) ? 32768 : 8;
    endfunction

    task automatic model_reset(input int i);
        m_mode[i] = MODE_HOLD; m_hold[i] = 0; m_count[i] = 0; m_nb[i] = 0;
        m_next[i] = 0; m_pend[i] = 0; m_flush[i] = 0; m_err[i] = 0;
        m_word[i] = 32'd0; e_core[i] = 0; e_busy[i] = 1;
    endtask

    task automatic model_step(input int i, input bit req, input bit en, input logic [7:0] d, input bit rdy);
        case (m_mode[i])
            MODE_RUN: if (req) begin m_mode[i] = MODE_ARM; e_core[i] = 0; e_busy[i] = 1; end
            MODE_ARM: begin
                m_count[i] = 0; m_err[i] = 0; m_nb[i] = 0; m_word[i] = 32'd0;
                m_next[i] = 0; m_mode[i] = MODE_LOAD;
            end
            MODE_LOAD: begin
                if (m_pend[i]) begin
                    if (en) m_err[i] = 1;
                    if (rdy) begin
                        m_pend[i] = 0; m_next[i] = (m_next[i] + 1) % 8192;
                        m_nb[i] = 0; m_word[i] = 32'd0;
                        if (m_flush[i]) begin m_mode[i] = MODE_HOLD; m_hold[i] = 0; end
                    end
                end else if (en) begin
                    if (m_count[i] < max_of(i)) begin
                        m_word[i] = m_word[i] | (32'(d) << (8 * m_nb[i]));
                        m_nb[i]++; m_count[i]++;
                        if (m_nb[i] == 4) begin
                            m_pend[i] = 1; m_flush[i] = 0;
                            e_addr[i] = m_next[i]; e_data[i] = m_word[i]; e_be[i] = 15;
                        end
                    end else begin
                        m_err[i] = 1;
                    end
                end else if (!req) begin
                    if (m_nb[i] > 0) begin
                        m_pend[i] = 1; m_flush[i] = 1;
                        e_addr[i] = m_next[i]; e_data[i] = m_word[i];
                        e_be[i] = (1 << m_nb[i]) - 1;
                    end else begin
                        m_mode[i] = MODE_HOLD; m_hold[i] = 0;
                    end
                end
            end
            MODE_HOLD: begin
                if (req) m_mode[i] = MODE_ARM;
                else if (m_hold[i] == HOLD - 1) begin
                    e_core[i] = 1; e_busy[i] = 0; m_mode[i] = MODE_RUN; m_hold[i] = 0;
                end else m_hold[i]++;
            end
            default: model_reset(i);
        endcase
    endtask

    // Advance the model on every rising edge from the inputs seen there.
    always @(posedge clk) begin
        if (rstB !== 1'b1) begin
            s1 = 1'b1; s2 = 1'b1;
            model_reset(0); model_reset(1);
            chk_en = 1'b1;
        end else begin
            m_req = !s2;
            model_step(0, m_req, rxDataEn, rxData, memWrReady);
            model_step(1, m_req, rxDataEn, rxData, memWrReady);
            s2 = s1; s1 = progEnB;
        end
    end

    task automatic cmp_inst(input int i, input logic core, input logic bsy, input logic wren,
                            input logic full, input logic [12:0] addr, input logic [31:0] data,
                            input logic [3:0] be, input logic [15:0] cnt, input logic er);
        chk("coreRstB", i, 64'(core), 64'(e_core[i]));
        chk("busy", i, 64'(bsy), 64'(e_busy[i]));
        chk("memWrEn", i, 64'(wren), 64'(m_pend[i]));
        chk("rxFfFull", i, 64'(full), 64'(m_pend[i]));
        chk("byteCount", i, 64'(cnt), 64'(m_count[i]));
        chk("err", i, 64'(er), 64'(m_err[i]));
        if (m_pend[i]) begin
            chk("memAddr", i, 64'(addr), 64'(e_addr[i]));
            chk("memWrData", i, 64'(data), 64'(e_data[i]));
            chk("memByteEn", i, 64'(be), 64'(e_be[i]));
        end
    endtask

    // Compare both instances against the model just after each edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            cmp_inst(0, coreRstB_a, busy_a, memWrEn_a, rxFfFull_a, memAddr_a,
                     memWrData_a, memByteEn_a, byteCount_a, err_a);
            cmp_inst(1, coreRstB_b, busy_b, memWrEn_b, rxFfFull_b, memAddr_b,
                     memWrData_b, memByteEn_b, byteCount_b, err_b);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        if (rnd_ready) memWrReady = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rxData = b; rxDataEn = 1'b1;
        tick();
        rxDataEn = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_release(output int rise_a);
        bit found = 0, got_a = 0;
        rise_a = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            tick();
            if (!got_a && coreRstB_a === 1'b1) begin got_a = 1; rise_a = cyc; end
            if (coreRstB_a === 1'b1 && coreRstB_b === 1'b1) found = 1;
        end
        chk("release_wait", 0, 64'(found), 64'd1);
    endtask

    initial begin
        int rise, na, nb, n;
        repeat (3) tick();
        chk("rst_core", 0, 64'(coreRstB_a), 64'd0);
        chk("rst_busy", 0, 64'(busy_a), 64'd1);
        chk("rst_wren", 0, 64'(memWrEn_a), 64'd0);
        chk("rst_full", 0, 64'(rxFfFull_a), 64'd0);
        chk("rst_addr", 0, 64'(memAddr_a), 64'd0);
        chk("rst_data", 0, 64'(memWrData_a), 64'd0);
        chk("rst_be", 0, 64'(memByteEn_a), 64'd0);
        chk("rst_cnt", 0, 64'(byteCount_a), 64'd0);
        chk("rst_err", 0, 64'(err_a), 64'd0);
        rstB = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            chk("rst_hold_core", k, 64'(coreRstB_a), 64'(k >= 4));
        end

        // Session 1: one full word, then a two-byte flush.
        progEnB = 1'b0;
        repeat (6) tick();
        send_byte(8'h13, 1); send_byte(8'h05, 1); send_byte(8'h10, 1); send_byte(8'h00, 1);
        repeat (3) tick();
        chk("s1_nwrites", 0, 64'(log_a.size()), 64'd1);
        chk("s1_word", 0, 64'(entry_a(0)), 64'({13'd0, 32'h00100513, 4'hF}));
        chk("s1_count", 0, 64'(byteCount_a), 64'd4);
        chk("s1_core", 0, 64'(coreRstB_a), 64'd0);
        send_byte(8'hAA, 1); send_byte(8'hBB, 1);
        progEnB = 1'b1;
        wait_release(rise);
        chk("s1_flush", 0, 64'(entry_a(1)), 64'({13'd1, 32'h0000BBAA, 4'b0011}));
        chk("s1_rel_delay", 0, 64'(rise - hs_cyc_a), 64'd4);

        // Session 2: write stalled ten cycles with a byte arriving mid-stall.
        memWrReady = 1'b0;
        progEnB = 1'b0;
        repeat (6) tick();
        send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h44, 0);
        for (int k = 0; k < 10; k++) begin
            rxDataEn = (k == 3);
            rxData = 8'hEE;
            chk("stall_wren", k, 64'(memWrEn_a), 64'd1);
            chk("stall_full", k, 64'(rxFfFull_a), 64'd1);
            chk("stall_addr", k, 64'(memAddr_a), 64'd0);
            chk("stall_data", k, 64'(memWrData_a), 64'h44332211);
            tick();
        end
        rxDataEn = 1'b0;
        chk("stall_err", 0, 64'(err_a), 64'd1);
        chk("stall_count", 0, 64'(byteCount_a), 64'd4);
        memWrReady = 1'b1;
        repeat (3) tick();
        chk("stall_word", 0, 64'(entry_a(2)), 64'({13'd0, 32'h44332211, 4'hF}));
        progEnB = 1'b1;
        wait_release(rise);

        // Session 3: nine bytes against the 8-byte instance.
        na = log_a.size(); nb = log_b.size();
        progEnB = 1'b0;
        repeat (6) tick();
        for (int b = 1; b <= 9; b++) send_byte(8'(b), 2);
        repeat (3) tick();
        chk("ovf_nwrites", 1, 64'(log_b.size() - nb), 64'd2);
        chk("ovf_w0", 1, 64'(entry_b(nb)), 64'({13'd0, 32'h04030201, 4'hF}));
        chk("ovf_w1", 1, 64'(entry_b(nb + 1)), 64'({13'd1, 32'h08070605, 4'hF}));
        chk("ovf_count", 1, 64'(byteCount_b), 64'd8);
        chk("ovf_err", 1, 64'(err_b), 64'd1);
        chk("ovf_count", 0, 64'(byteCount_a), 64'd9);
        chk("ovf_err", 0, 64'(err_a), 64'd0);
        progEnB = 1'b1;
        wait_release(rise);
        chk("ovf_flush1", 0, 64'(entry_a(na + 2)), 64'({13'd2, 32'h00000009, 4'b0001}));

        // Session 4: reset mid-word aborts, next session restarts at base.
        progEnB = 1'b0;
        repeat (6) tick();
        send_byte(8'h5A, 1); send_byte(8'h5B, 1);
        na = log_a.size();
        rstB = 1'b0; progEnB = 1'b1;
        #1;
        chk("abort_core", 0, 64'(coreRstB_a), 64'd0);
        chk("abort_wren", 0, 64'(memWrEn_a), 64'd0);
        chk("abort_count", 0, 64'(byteCount_a), 64'd0);
        chk("abort_busy", 0, 64'(busy_a), 64'd1);
        repeat (2) tick();
        rstB = 1'b1;
        wait_release(rise);
        chk("abort_nowrite", 0, 64'(log_a.size()), 64'(na));
        progEnB = 1'b0;
        repeat (6) tick();
        send_byte(8'hC0, 1); send_byte(8'hC1, 1); send_byte(8'hC2, 1); send_byte(8'hC3, 1);
        repeat (3) tick();
        chk("abort_restart", 0, 64'(entry_a(na)), 64'({13'd0, 32'hC3C2C1C0, 4'hF}));
        progEnB = 1'b1;
        wait_release(rise);

        // Randomised sessions with random write backpressure.
        rnd_ready = 1'b1;
        repeat (10) begin
            progEnB = 1'b0;
            repeat ($urandom_range(3, 8)) tick();
            n = $urandom_range(0, 14);
            for (int j = 0; j < n; j++) send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 3));
            progEnB = 1'b1;
            repeat ($urandom_range(1, 10)) tick();
        end
        rnd_ready = 1'b0;
        memWrReady = 1'b1;
        wait_release(rise);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
